// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU opcode, register index and the ID/EX payload
// carried between the decode and execute stages.
package pipeline_pkg;

  typedef logic [4:0] alu_op_t;
  typedef logic [4:0] reg_idx_t;

  localparam alu_op_t  ALU_NOP  = 5'd0;
  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    alu_op_t     alu_op;
    logic [31:0] ext_imm;
    reg_idx_t    rs;
    reg_idx_t    rt;
    reg_idx_t    rd;
    logic [4:0]  shamt;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        mem_read;
    logic        reg_write;
  } idex_t;

  // A bubble is an all-zero payload: ALU_NOP, no load, no write-back.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/idex_hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary and the resulting
// front-end stall request.
module idex_hazard_unit
  import pipeline_pkg::*;
(
  input  logic       reset,
  input  logic       flush,
  input  logic       ex_stall,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hz,
  output logic       id_stall
);

  logic rt_match;

  always_comb begin
    rt_match = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
    // A load targeting $zero never produces a value anyone waits for.
    hz       = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid && rt_match;
    id_stall = !reset && !flush && (ex_stall || hz);
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure,
// flush, and a saturating bubble counter for the performance monitor.
module idex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_alu_op,
  input  logic [31:0]      id_ext_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic [31:0]      id_read_data1,
  input  logic [31:0]      id_read_data2,
  input  logic             id_mem_read,
  input  logic             id_reg_write,
  input  logic             id_uses_rt,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [4:0]       ex_alu_op,
  output logic [31:0]      ex_ext_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic [31:0]      ex_read_data1,
  output logic [31:0]      ex_read_data2,
  output logic             ex_mem_read,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  idex_t            ex_q, ex_d, id_pkt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;

  idex_hazard_unit u_hazard (
    .reset       (reset),
    .flush       (flush),
    .ex_stall    (ex_stall),
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rt       (ex_q.rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hz          (hz),
    .id_stall    (id_stall)
  );

  always_comb begin
    id_pkt = '{
      valid:      id_valid,
      alu_op:     id_alu_op,
      ext_imm:    id_ext_imm,
      rs:         id_rs,
      rt:         id_rt,
      rd:         id_rd,
      shamt:      id_shamt,
      read_data1: id_read_data1,
      read_data2: id_read_data2,
      mem_read:   id_mem_read,
      reg_write:  id_reg_write
    };
    ex_d  = ex_q;
    cnt_d = cnt_q;
    // Flush outranks the hazard so a killed instruction is never counted.
    if (flush) begin
      ex_d = IDEX_BUBBLE;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d = IDEX_BUBBLE;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= IDEX_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_ext_imm    = ex_q.ext_imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_shamt      = ex_q.shamt;
  assign ex_read_data1 = ex_q.read_data1;
  assign ex_read_data2 = ex_q.read_data2;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_reg_write  = ex_q.reg_write;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_idex_stage_reg;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] d1, d2;
    logic        mr, rw;
  } exs_t;

  typedef struct packed {
    exs_t        ins;
    logic        uses_rt;
  } instr_t;

  typedef struct packed {
    exs_t             st;
    logic             stall;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, id_valid, id_mem_read, id_reg_write, id_uses_rt, ex_stall, flush;
  logic [4:0]       id_alu_op, id_rs, id_rt, id_rd, id_shamt;
  logic [31:0]      id_ext_imm, id_read_data1, id_read_data2;
  logic             id_stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [4:0]       ex_alu_op, ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [31:0]      ex_ext_imm, ex_read_data1, ex_read_data2;
  logic [CNT_W-1:0] bubble_cnt;

  idex_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_ext_imm(id_ext_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_uses_rt(id_uses_rt),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_ext_imm(ex_ext_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_read_data1(ex_read_data1),
    .ex_read_data2(ex_read_data2), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  exs_t             m_ex = '0;
  int unsigned      m_cnt = 0;
  logic             last_stall = 1'b0;

  // Reference: what a pipeline stage does with a load in EX and a consumer in ID.
  function automatic logic waits_on_load(input exs_t ex, input instr_t id);
    logic reads_it;
    if (!(ex.valid && ex.mr) || ex.rt == 5'd0 || !id.ins.valid) return 1'b0;
    reads_it = (id.ins.rs == ex.rt) || (id.uses_rt && id.ins.rt == ex.rt);
    return reads_it;
  endfunction

  task automatic cycle(input instr_t in, input logic rst, input logic fl, input logic exs);
    exp_t e;
    logic hz;
    @(posedge clk);
    #2;
    reset = rst; flush = fl; ex_stall = exs;
    id_valid = in.ins.valid; id_alu_op = in.ins.alu; id_ext_imm = in.ins.imm;
    id_rs = in.ins.rs; id_rt = in.ins.rt; id_rd = in.ins.rd; id_shamt = in.ins.sh;
    id_read_data1 = in.ins.d1; id_read_data2 = in.ins.d2;
    id_mem_read = in.ins.mr; id_reg_write = in.ins.rw; id_uses_rt = in.uses_rt;
    hz = waits_on_load(m_ex, in);
    e.st    = m_ex;
    e.cnt   = CNT_W'(m_cnt);
    e.stall = !rst && !fl && (exs || hz);
    sb.push_back(e);
    last_stall = e.stall;
    if (rst) begin
      m_ex = '0; m_cnt = 0;
    end else if (fl) begin
      m_ex = '0;
    end else if (exs) begin
      // EX frozen
    end else if (hz) begin
      m_ex = '0;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end else begin
      m_ex = in.ins;
    end
  endtask

  task automatic issue(input instr_t in);
    int unsigned n = 0;
    do begin
      cycle(in, 1'b0, 1'b0, 1'b0);
      n++;
    end while (last_stall && n < 20);
  endtask

  function automatic instr_t mk(input logic [4:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic mr, input logic uses_rt);
    instr_t i;
    i.ins.valid = 1'b1; i.ins.alu = alu; i.ins.imm = $urandom;
    i.ins.rs = rs; i.ins.rt = rt; i.ins.rd = rd; i.ins.sh = 5'($urandom);
    i.ins.d1 = $urandom; i.ins.d2 = $urandom; i.ins.mr = mr; i.ins.rw = 1'b1;
    i.uses_rt = uses_rt;
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    i = mk(5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
    i.ins.valid = ($urandom_range(0, 7) != 0);
    i.ins.rw = 1'($urandom);
    return i;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{valid: ex_valid, alu: ex_alu_op, imm: ex_ext_imm, rs: ex_rs, rt: ex_rt,
            rd: ex_rd, sh: ex_shamt, d1: ex_read_data1, d2: ex_read_data2,
            mr: ex_mem_read, rw: ex_reg_write};
      n_cmp++;
      if (a !== e.st) begin
        n_bad++;
        $display("FAIL ex_regs @%0t: got %h expected %h", $time, a, e.st);
      end
      n_cmp++;
      if (bubble_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL bubble_cnt @%0t: got %h expected %h", $time, bubble_cnt, e.cnt);
      end
      n_cmp++;
      if (id_stall !== e.stall) begin
        n_bad++;
        $display("FAIL id_stall @%0t: got %b expected %b", $time, id_stall, e.stall);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t lw5, add5, lw0, add0, addi5, cur;
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b1;
    id_alu_op = '0; id_ext_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
    id_read_data1 = '0; id_read_data2 = '0; id_mem_read = 1'b0; id_reg_write = 1'b0;
    id_uses_rt = 1'b0;

    lw5   = mk(5'd3, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
    add5  = mk(5'd1, 5'd5, 5'd2, 5'd7, 1'b0, 1'b1);
    lw0   = mk(5'd3, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    add0  = mk(5'd1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1);
    addi5 = mk(5'd2, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);

    // reset held two cycles with a valid instruction in ID
    cycle(lw5, 1'b1, 1'b0, 1'b0);
    cycle(lw5, 1'b1, 1'b0, 1'b0);
    // load-use: one bubble, then the consumer enters EX
    issue(lw5); issue(add5); issue(mk(5'd0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0));
    // $zero target and non-rt consumer: no stall
    issue(lw0); issue(add0); issue(lw5); issue(addi5);
    // EX back-pressure during a hazard, then the bubble
    issue(lw5);
    repeat (3) cycle(add5, 1'b0, 1'b0, 1'b1);
    issue(add5);
    // flush coincident with a hazard
    issue(lw5);
    cycle(add5, 1'b0, 1'b1, 1'b0);
    issue(add0);
    // drive the counter into saturation and beyond
    for (int i = 0; i < 18; i++) begin
      issue(lw5); issue(add5);
    end
    // hazard pending when reset arrives
    issue(lw5);
    cycle(add5, 1'b1, 1'b0, 1'b0);
    issue(add5);
    // random traffic; ID is held whenever the model says it must stall
    cur = rnd();
    for (int i = 0; i < 600; i++) begin
      cycle(cur, ($urandom_range(0, 60) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 4) == 0));
      if (!last_stall) cur = rnd();
    end
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
